// File: rtl/seq_alu.sv
// seq_alu: sequential ALU. Single-cycle ops 0-9; iterative shift-add multiply
// and restoring divide for ops 10-15 when SEQ_ALU_MULDIV_EN is defined.
// Without SEQ_ALU_MULDIV_EN, ops 10-15 complete in one cycle with a zero result.
module seq_alu #(
  parameter int unsigned DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          valid_i,
  input  logic [3:0]    ALUctrl_i,
  input  logic [DW-1:0] ALUop1_i,
  input  logic [DW-1:0] ALUop2_i,
  output logic          ready_o,
  output logic          out_valid_o,
  output logic [DW-1:0] ALUout_o,
  output logic          Eq_o
);

  localparam int unsigned SW = $clog2(DW);
`ifdef SEQ_ALU_MULDIV_EN
  localparam int unsigned CW  = SW + 1;
  localparam int unsigned DW2 = 2 * DW;
`endif

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLT   = 4'd5;
  localparam logic [3:0] OP_SLTU  = 4'd6;
  localparam logic [3:0] OP_SLL   = 4'd7;
  localparam logic [3:0] OP_SRL   = 4'd8;
  localparam logic [3:0] OP_SRA   = 4'd9;
`ifdef SEQ_ALU_MULDIV_EN
  localparam logic [3:0] OP_MULHU = 4'd11;
`endif

  // Elaboration-time guard on the operand width
  if (DW < 8 || DW > 64 || (DW & (DW - 1)) != 0) begin : g_bad_dw
    $error("seq_alu: DW must be a power of two between 8 and 64");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
`ifdef SEQ_ALU_MULDIV_EN
    S_MUL  = 2'd2,
    S_DIV  = 2'd3,
`endif
    S_DONE = 2'd1
  } state_e;

  state_e        state_q, state_d;
  logic          ready_q, ready_d;
  logic          out_valid_q, out_valid_d;
  logic          eq_q, eq_d;
  logic [DW-1:0] res_q, res_d;

  logic [DW-1:0] alu_res;
  logic [SW-1:0] shamt;
  logic          op_eq;

`ifdef SEQ_ALU_MULDIV_EN
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [3:0]     op_q, op_d;
  logic [DW2-1:0] acc_q, acc_d;
  logic [DW-1:0]  opnd_q, opnd_d;
  logic [DW-1:0]  op1_q, op1_d;
  logic           qneg_q, qneg_d;
  logic           rneg_q, rneg_d;
  logic           dz_q, dz_d;
  logic           eqp_q, eqp_d;

  logic           is_mul, is_div;
  logic           sgn, neg1, neg2;
  logic [DW-1:0]  mag1, mag2;
  logic [DW:0]    mul_sum;
  logic [DW2-1:0] mul_acc;
  logic [DW:0]    div_shift, div_diff;
  logic [DW-1:0]  div_rem, div_quo;
  logic [DW-1:0]  div_q_fin, div_r_fin;
`endif

  assign shamt = ALUop2_i[SW-1:0];
  assign op_eq = (ALUop1_i == ALUop2_i);

  // Single-cycle result for the opcode currently on the inputs
  always_comb begin
    alu_res = '0;
    case (ALUctrl_i)
      OP_ADD:  alu_res = ALUop1_i + ALUop2_i;
      OP_SUB:  alu_res = ALUop1_i - ALUop2_i;
      OP_AND:  alu_res = ALUop1_i & ALUop2_i;
      OP_OR:   alu_res = ALUop1_i | ALUop2_i;
      OP_XOR:  alu_res = ALUop1_i ^ ALUop2_i;
      OP_SLT:  alu_res = DW'($signed(ALUop1_i) < $signed(ALUop2_i));
      OP_SLTU: alu_res = DW'(ALUop1_i < ALUop2_i);
      OP_SLL:  alu_res = ALUop1_i << shamt;
      OP_SRL:  alu_res = ALUop1_i >> shamt;
      OP_SRA:  alu_res = DW'($unsigned($signed(ALUop1_i) >>> shamt));
      default: alu_res = '0;
    endcase
  end

`ifdef SEQ_ALU_MULDIV_EN
  // Operand decode for the iterative ops: magnitudes for signed divide
  always_comb begin
    is_mul = (ALUctrl_i[3:1] == 3'b101);
    is_div = (ALUctrl_i[3:2] == 2'b11);
    sgn    = ~ALUctrl_i[0];
    neg1   = sgn & ALUop1_i[DW-1];
    neg2   = sgn & ALUop2_i[DW-1];
    mag1   = neg1 ? (-ALUop1_i) : ALUop1_i;
    mag2   = neg2 ? (-ALUop2_i) : ALUop2_i;
  end

  // One multiply step (acc = {partial, multiplier}) and one restoring-divide
  // step (acc = {remainder, dividend/quotient})
  always_comb begin
    mul_sum   = {1'b0, acc_q[DW2-1:DW]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_acc   = {mul_sum, acc_q[DW-1:1]};
    div_shift = {acc_q[DW2-1:DW], acc_q[DW-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (!div_diff[DW]) begin
      div_rem = div_diff[DW-1:0];
      div_quo = {acc_q[DW-2:0], 1'b1};
    end else begin
      div_rem = div_shift[DW-1:0];
      div_quo = {acc_q[DW-2:0], 1'b0};
    end
    div_q_fin = dz_q ? '1    : (qneg_q ? (-div_quo) : div_quo);
    div_r_fin = dz_q ? op1_q : (rneg_q ? (-div_rem) : div_rem);
  end
`endif

  // Next-state, result capture and datapath sequencing
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    eq_d    = eq_q;
`ifdef SEQ_ALU_MULDIV_EN
    cnt_d   = cnt_q;
    op_d    = op_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    op1_d   = op1_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    eqp_d   = eqp_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
`ifdef SEQ_ALU_MULDIV_EN
          if (is_mul) begin
            op_d    = ALUctrl_i;
            acc_d   = {{DW{1'b0}}, ALUop1_i};
            opnd_d  = ALUop2_i;
            cnt_d   = CW'(DW);
            eqp_d   = op_eq;
            state_d = S_MUL;
          end else if (is_div) begin
            op_d    = ALUctrl_i;
            acc_d   = {{DW{1'b0}}, mag1};
            opnd_d  = mag2;
            op1_d   = ALUop1_i;
            qneg_d  = neg1 ^ neg2;
            rneg_d  = neg1;
            dz_d    = (ALUop2_i == '0);
            cnt_d   = CW'(DW);
            eqp_d   = op_eq;
            state_d = S_DIV;
          end else begin
            res_d   = alu_res;
            eq_d    = op_eq;
            state_d = S_DONE;
          end
`else
          res_d   = alu_res;
          eq_d    = op_eq;
          state_d = S_DONE;
`endif
        end
      end
`ifdef SEQ_ALU_MULDIV_EN
      S_MUL: begin
        acc_d = mul_acc;
        cnt_d = cnt_q - CW'(1);
        if (cnt_d == '0) begin
          res_d   = (op_q == OP_MULHU) ? mul_acc[DW2-1:DW] : mul_acc[DW-1:0];
          eq_d    = eqp_q;
          state_d = S_DONE;
        end
      end
      S_DIV: begin
        acc_d = {div_rem, div_quo};
        cnt_d = cnt_q - CW'(1);
        if (cnt_d == '0) begin
          res_d   = op_q[1] ? div_r_fin : div_q_fin;
          eq_d    = eqp_q;
          state_d = S_DONE;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ready_d     = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b1;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      eq_q        <= 1'b0;
`ifdef SEQ_ALU_MULDIV_EN
      cnt_q       <= '0;
      op_q        <= '0;
      acc_q       <= '0;
      opnd_q      <= '0;
      op1_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      dz_q        <= 1'b0;
      eqp_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      eq_q        <= eq_d;
`ifdef SEQ_ALU_MULDIV_EN
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      opnd_q      <= opnd_d;
      op1_q       <= op1_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      dz_q        <= dz_d;
      eqp_q       <= eqp_d;
`endif
    end
  end

  assign ready_o     = ready_q;
  assign out_valid_o = out_valid_q;
  assign ALUout_o    = res_q;
  assign Eq_o        = eq_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed, table-driven bench for seq_alu (DW=32); expectations follow
// whether SEQ_ALU_MULDIV_EN is defined for the build.
module tb_seq_alu;

  localparam int unsigned DW = 32;
`ifdef SEQ_ALU_MULDIV_EN
  localparam bit MD     = 1'b1;
  localparam int MD_LAT = DW + 1;
`else
  localparam bit MD     = 1'b0;
  localparam int MD_LAT = 1;
`endif

  logic          clk_i;
  logic          rst_ni;
  logic          valid_i;
  logic [3:0]    ALUctrl_i;
  logic [DW-1:0] ALUop1_i;
  logic [DW-1:0] ALUop2_i;
  logic          ready_o;
  logic          out_valid_o;
  logic [DW-1:0] ALUout_o;
  logic          Eq_o;

  seq_alu #(.DW(DW)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .valid_i     (valid_i),
    .ALUctrl_i   (ALUctrl_i),
    .ALUop1_i    (ALUop1_i),
    .ALUop2_i    (ALUop2_i),
    .ready_o     (ready_o),
    .out_valid_o (out_valid_o),
    .ALUout_o    (ALUout_o),
    .Eq_o        (Eq_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] res;
    logic          eq;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_junk(input logic v);
    valid_i   = v;
    ALUctrl_i = 4'($urandom);
    ALUop1_i  = $urandom;
    ALUop2_i  = $urandom;
  endtask

  // Issue one op, hammer valid_i while busy, then check result, latency and hold
  task automatic run_op(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] res, input logic eq, input int exp_lat,
                        input string tag);
    int lat;
    bit seen;
    bit busy_ok;
    lat = 0; seen = 0; busy_ok = 1;
    @(negedge clk_i);
    chk({tag, " ready_before"}, 64'(ready_o), 64'd1);
    valid_i = 1'b1; ALUctrl_i = op; ALUop1_i = a; ALUop2_i = b;
    @(posedge clk_i);
    #1;
    drive_junk(1'b0);
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk_i);
      if (out_valid_o === 1'b1) begin
        lat = c;
        seen = 1;
        break;
      end
      if (ready_o !== 1'b0) busy_ok = 0;
      drive_junk(1'(c % 2));
    end
    chk({tag, " out_valid"}, 64'(seen), 64'd1);
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " result"}, 64'(ALUout_o), 64'(res));
    chk({tag, " eq"}, 64'(Eq_o), 64'(eq));
    if (exp_lat > 1) chk({tag, " busy_ready_low"}, 64'(busy_ok), 64'd1);
    // valid in the DONE cycle must not be taken
    drive_junk(1'b1);
    @(negedge clk_i);
    drive_junk(1'b0);
    chk({tag, " pulse_one_cycle"}, 64'(out_valid_o), 64'd0);
    chk({tag, " back_to_idle"}, 64'(ready_o), 64'd1);
    chk({tag, " result_hold"}, 64'(ALUout_o), 64'(res));
    chk({tag, " eq_hold"}, 64'(Eq_o), 64'(eq));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] exp_res;
    int            exp_lat;
    int            pulses;

    // op, a, b, result (multiply/divide build), eq
    vecs.push_back('{4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0});
    vecs.push_back('{4'd1,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0});
    vecs.push_back('{4'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0});
    vecs.push_back('{4'd3,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0});
    vecs.push_back('{4'd4,  32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1});
    vecs.push_back('{4'd5,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0});
    vecs.push_back('{4'd6,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0});
    vecs.push_back('{4'd5,  32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0});
    vecs.push_back('{4'd5,  32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1'b1});
    vecs.push_back('{4'd7,  32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1'b0});
    vecs.push_back('{4'd8,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0});
    vecs.push_back('{4'd9,  32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0});
    vecs.push_back('{4'd10, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1});
    vecs.push_back('{4'd11, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 1'b1});
    vecs.push_back('{4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1});
    vecs.push_back('{4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1});
    vecs.push_back('{4'd10, 32'h0000_0003, 32'h0000_0003, 32'h0000_0009, 1'b1});
    vecs.push_back('{4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0});
    vecs.push_back('{4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0});
    vecs.push_back('{4'd13, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0});
    vecs.push_back('{4'd15, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 1'b0});
    vecs.push_back('{4'd12, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0});
    vecs.push_back('{4'd14, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0});
    vecs.push_back('{4'd12, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0});
    vecs.push_back('{4'd14, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 1'b0});
    vecs.push_back('{4'd13, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 1'b0});
    vecs.push_back('{4'd15, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 1'b0});
    vecs.push_back('{4'd12, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0});
    vecs.push_back('{4'd14, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0});

    // Reset with valid_i held high
    rst_ni = 1'b0;
    valid_i = 1'b1; ALUctrl_i = 4'd0; ALUop1_i = 32'd1; ALUop2_i = 32'd1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset ready", 64'(ready_o), 64'd1);
    chk("reset out_valid", 64'(out_valid_o), 64'd0);
    chk("reset result", 64'(ALUout_o), 64'd0);
    chk("reset eq", 64'(Eq_o), 64'd0);
    valid_i = 1'b0;
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("post_reset out_valid", 64'(out_valid_o), 64'd0);
    chk("post_reset ready", 64'(ready_o), 64'd1);

    // Table of vectors
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].op >= 4'd10) begin
        exp_res = MD ? vecs[i].res : '0;
        exp_lat = MD_LAT;
      end else begin
        exp_res = vecs[i].res;
        exp_lat = 1;
      end
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, exp_res, vecs[i].eq, exp_lat,
             $sformatf("vec%0d_op%0d", i, vecs[i].op));
    end

    // Leave a non-zero result and Eq=1 so the reset clearing is visible
    run_op(4'd0, 32'd1, 32'd1, 32'd2, 1'b1, 1, "pre_reset_add");

`ifdef SEQ_ALU_MULDIV_EN
    // Abort an in-flight DIVU with a one-cycle reset at cycle 10
    @(negedge clk_i);
    valid_i = 1'b1; ALUctrl_i = 4'd13; ALUop1_i = 32'd100; ALUop2_i = 32'd7;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    pulses = 0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk_i);
      if (out_valid_o === 1'b1) pulses++;
    end
    chk("abort no_early_pulse", 64'(pulses), 64'd0);
`endif
    rst_ni = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    chk("midreset ready", 64'(ready_o), 64'd1);
    chk("midreset out_valid", 64'(out_valid_o), 64'd0);
    chk("midreset result", 64'(ALUout_o), 64'd0);
    chk("midreset eq", 64'(Eq_o), 64'd0);

    // Accept in the first cycle after reset release
    rst_ni = 1'b1;
    valid_i = 1'b1; ALUctrl_i = 4'd0; ALUop1_i = 32'd2; ALUop2_i = 32'd2;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    @(negedge clk_i);
    chk("after_reset add out_valid", 64'(out_valid_o), 64'd1);
    chk("after_reset add result", 64'(ALUout_o), 64'd4);
    chk("after_reset add eq", 64'(Eq_o), 64'd1);

    // The aborted operation must never produce a late pulse
    pulses = 0;
    for (int c = 0; c < 2 * DW; c++) begin
      @(negedge clk_i);
      if (out_valid_o === 1'b1) pulses++;
    end
    chk("no_stray_pulse", 64'(pulses), 64'd0);
    chk("final result_hold", 64'(ALUout_o), 64'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter DW, default 32, operand/result width in bits; SHALL be a power of two, 8 to 64.
REQ-002 clk_i  in  1  clock; all state SHALL update on the rising edge only.
REQ-003 rst_ni  in  1  reset, synchronous, active-low.
REQ-004 valid_i  in  1  operation request; a request SHALL be accepted in a cycle where valid_i=1 and ready_o=1.
REQ-005 ALUctrl_i  in  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 MUL, 11 MULHU, 12 DIV, 13 DIVU, 14 REM, 15 REMU.
REQ-006 ALUop1_i  in  DW  operand 1; sampled only at accept.
REQ-007 ALUop2_i  in  DW  operand 2; sampled only at accept.
REQ-008 ready_o  out  1  block idle and able to accept.
REQ-009 out_valid_o  out  1  single-cycle pulse; ALUout_o and Eq_o valid in that cycle.
REQ-010 ALUout_o  out  DW  registered result.
REQ-011 Eq_o  out  1  registered (op1==op2) of the accepted operands.

Function
REQ-012 FSM states: IDLE, MUL, DIV, DONE; ready_o SHALL be 1 only in IDLE.
REQ-013 IDLE, accept, opcode 0-9: result computed combinationally, registered, and the FSM SHALL move to DONE; out_valid_o=1 the cycle after accept (latency 1).
REQ-014 IDLE, accept, opcode 10-11: FSM SHALL enter MUL; shift-add, one operand bit per cycle, DW cycles; then DONE; latency DW+1.
REQ-015 IDLE, accept, opcode 12-15: FSM SHALL enter DIV; restoring division, one quotient bit per cycle, DW cycles; then DONE; latency DW+1.
REQ-016 DONE SHALL last exactly one cycle with out_valid_o=1 and SHALL return to IDLE; no back-to-back accept in DONE.
REQ-017 ALUout_o and Eq_o SHALL hold their value until the next out_valid_o pulse.
REQ-018 Arithmetic modulo 2^DW; SUB = op1 - op2; SLT signed, SLTU unsigned; result 1 or 0 zero-extended.
REQ-019 Shifts SHALL use op2[log2(DW)-1:0] only; SRA sign-fills.
REQ-020 MUL SHALL return the low DW bits of the product; MULHU the high DW bits of the unsigned 2*DW product.
REQ-021 DIV/REM signed, truncate toward zero; REM sign follows the dividend; DIVU/REMU unsigned.
REQ-022 Divide by zero: quotient all-ones, remainder = op1, full DW+1 latency retained.
REQ-023 Signed overflow (op1 = most-negative, op2 = -1): DIV result op1, REM result 0.
REQ-024 valid_i while ready_o=0 SHALL be ignored, with no queuing and no effect on the in-flight operation.
REQ-025 An iteration counter of width log2(DW)+1 SHALL count DW down to 0; the exit SHALL occur when the counter reaches 0, with no wrap.

Reset
REQ-026 rst_ni=0 at a clock edge SHALL force IDLE, ready_o=1, out_valid_o=0, ALUout_o=0, Eq_o=0, and clear the counter and internal registers.
REQ-027 Reset in MUL or DIV SHALL abort the operation with no out_valid_o pulse; accept is possible in the first cycle after rst_ni returns to 1.
REQ-028 valid_i SHALL be ignored while rst_ni=0.

Configuration
REQ-029 Macro SEQ_ALU_MULDIV_EN: when defined, opcodes 10-15 SHALL behave per REQ-014, REQ-015 and REQ-020 to REQ-023.
REQ-030 When SEQ_ALU_MULDIV_EN is undefined: MUL/DIV states and datapath SHALL be absent; opcodes 10-15 SHALL complete with latency 1, ALUout_o=0, and Eq_o computed normally.

Verification
REQ-031 DW=32, ADD 0xFFFFFFFF+0x00000001 -> out_valid_o the next cycle, ALUout_o=0x00000000, Eq_o=0.
REQ-032 SRA 0x80000000 by op2=0x00000024 -> shift 4, ALUout_o=0xF8000000; SLT 0xFFFFFFFF vs 0x1 -> 1; SLTU -> 0.
REQ-033 MUL 0x00010000*0x00010000 -> ALUout_o=0 after 33 cycles; MULHU same operands -> 0x00000001; ready_o=0 throughout, valid_i pulses ignored.
REQ-034 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0; DIVU 7/0 -> 0xFFFFFFFF; REMU 7/0 -> 7; DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
REQ-035 Start DIVU, assert rst_ni=0 at cycle 10 for one cycle -> no out_valid_o, all outputs at reset values, ready_o=1; new ADD 2+2 accepted next cycle -> 4.
REQ-036 Build without SEQ_ALU_MULDIV_EN, MUL 3*3 with equal operands -> latency 1, ALUout_o=0, Eq_o=1.
